approx_mult_seq: RTL
====================

Name: approx_mult_seq

Overview:
- Parametrised, iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Successor to the fixed 4x4 approximate array multiplier.
- Low columns of the accumulate adder can use the approximate cell: SUM = partial-product bit, CARRY-out = accumulator bit. Number of approximate columns is set by a parameter.
- Approximation is enabled or disabled per operation. Operations use valid/ready handshakes on both input and output sides, for use in datapath accelerators.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- APPROX_COLS, 3, count of low result columns (bits 0..APPROX_COLS-1) built from approximate cells; legal range 0..2*WIDTH. 0 means always exact.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- in_approx  in  1  1 = approximate columns active for this operation; 0 = fully exact.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  2*WIDTH  product.
- out_approx  out  1  in_approx value captured with this operation.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - out_valid = 0, out_result = 0, out_approx = 0.
  - Internal accumulator, row counter and captured operands = 0.
  - in_ready = 1 in the first cycle after reset deassertion.
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture in_a, in_b, in_approx; clear accumulator; set row counter i = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge: acc <= add_cell(acc, ({WIDTH'b0, a} & {2*WIDTH{b[i]}}) << i); i <= i+1.
  - After row WIDTH-1, go to DONE. RUN lasts exactly WIDTH cycles.
- add_cell ripple rule, bit j from 0 upward, carry c0 = 0, x = acc bit, y = partial-product bit:
  - If (captured approx = 1) and (j < APPROX_COLS): sum_j = y, c(j+1) = x. Incoming carry cj is ignored.
  - Otherwise exact full adder: sum_j = x^y^cj, c(j+1) = majority(x, y, cj).
  - Carry out of bit 2*WIDTH-1 is discarded.
- Rows with b[i] = 0 are still processed. Zero rows still alter the approximate columns; fixed latency is required.
- DONE:
  - out_valid = 1; out_result = acc; out_approx = captured flag.
  - Both held stable until an edge with out_ready = 1, then go to IDLE with out_valid = 0.
  - out_result keeps its last value after the handshake.
- Latency and throughput:
  - Acceptance edge T0 -> out_valid visible after edge T0+WIDTH.
  - Minimum issue interval WIDTH+2 cycles (out_ready held high).
- in_valid, in_a, in_b are ignored while not IDLE; no buffering. Upstream must hold in_valid until in_ready.
- out_ready while out_valid = 0 has no effect.
- Approximation is per operation: a change of in_approx during RUN or DONE does not affect the operation in flight.
- Reset asserted mid-RUN or in DONE: operation discarded immediately; no out_valid pulse.
- With in_approx = 0, or APPROX_COLS = 0, out_result must equal a*b exactly for all operands.

Test Plan:
- WIDTH=4, APPROX_COLS=3, in_approx=0, a=15, b=15 -> out_valid 4 cycles after accept; out_result=225; out_approx=0.
- Same config, in_approx=1, a=15, b=15 -> out_result=232 (0xE8); intermediate accumulator after rows 0/1/2 = 15/46/108; out_approx=1.
- WIDTH=4, APPROX_COLS=0, exhaustive 256 pairs, in_approx random -> every result equals a*b.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and out_approx stable, in_ready=0 throughout, new in_valid with a=3, b=5 ignored; release out_ready -> in_ready=1 next cycle, then 3*5=15.
- Reset pulse during RUN (after row 1) -> out_valid stays 0, in_ready=1 after release; a=2, b=3 then yields 6.
- WIDTH=8, APPROX_COLS=16, in_approx=1, random pairs vs bit-level golden model -> exact match; a=255, b=0 -> result equals golden (0); b=0 also checked with APPROX_COLS=0 -> 0.

Source files
------------

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: iterative shift-add unsigned multiplier, WIDTH x WIDTH.
// Low result columns may use approximate adder cells, chosen per operation.
module approx_mult_seq #(
  parameter int WIDTH       = 4,
  parameter int APPROX_COLS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_approx
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             approx_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    sum;
  logic [CW-1:0]    cnt;

  // Approximate cell passes the row bit through and forwards acc as carry.
  always_comb begin
    logic c;
    pp  = ({{WIDTH{1'b0}}, a_q} & {PW{b_q[cnt]}}) << cnt;
    sum = '0;
    c   = 1'b0;
    for (int j = 0; j < PW; j++) begin
      if (approx_q && (j < APPROX_COLS)) begin
        sum[j] = pp[j];
        c      = acc[j];
      end else begin
        sum[j] = acc[j] ^ pp[j] ^ c;
        c      = (acc[j] & pp[j]) | (acc[j] & c) | (pp[j] & c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_approx <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      approx_q   <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            approx_q <= in_approx;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            out_valid  <= 1'b1;
            out_result <= sum;
            out_approx <= approx_q;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
